// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg: shared widths, FSM/owner encodings for ram_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 8;

  localparam int DEF_DATA_WIDTH = 8;

  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ARB_ST_IDLE     = 2'd0,
    ARB_ST_ISSUE    = 2'd1,
    ARB_ST_COMPLETE = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_P0 = 1'b0,
    ARB_OWN_P1 = 1'b1
  } arb_owner_e;

  function automatic arb_owner_e other_port(input arb_owner_e p);
    return (p == ARB_OWN_P0) ? ARB_OWN_P1 : ARB_OWN_P0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if: two master req/ack ports plus the RAM pins. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic                  lock0;
  logic                  lock1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_data_wr;
  logic [DATA_WIDTH-1:0] ram_data_rd;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1,
    output ram_addr, ram_wr_en, ram_data_wr,
    input  ram_data_rd
  );

  // Masters plus RAM model side
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1,
    input  ram_addr, ram_wr_en, ram_data_wr,
    output ram_data_rd
  );

endinterface

`default_nettype wire

// File: rtl/ram_arbiter_arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2: combinational 2-way picker (lock, round-robin or fixed). Rev 1.0
// Optional: RAM_ARB_FIXED_PRIO_EN gives port 0 every tie.
// ---------------------------------------------------------------------------
`default_nettype none

module arb_pick2
  import ram_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_owner_e last_grant,
  input  logic       locked,
  input  arb_owner_e owner,
  output logic       grant_valid,
  output arb_owner_e grant_idx
);

  logic owner_req;

  assign owner_req = (owner == ARB_OWN_P1) ? req1 : req0;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == ARB_OWN_P1);
`endif

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = ARB_OWN_P0;
    if (locked && owner_req) begin
      grant_idx = owner;
    end else if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      grant_idx = ARB_OWN_P0;
`else
      grant_idx = other_port(last_grant);
`endif
    end else if (req1) begin
      grant_idx = ARB_OWN_P1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter: shares one single-port RAM between two req/ack masters. Rev 1.0
// Optional: RAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority on ties.
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input logic          clk,
  input logic          arst,
  ram_arbiter_if.slave bus
);

  localparam int              CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e            state;
  arb_state_e            next_state;
  arb_owner_e            owner;
  arb_owner_e            last_grant;
  arb_owner_e            grant_idx;
  logic                  grant_valid;
  logic                  locked;
  logic [CNT_W-1:0]      burst_cnt;
  logic                  we_lat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  owner_req;
  logic                  owner_lock;
  logic                  ack0;
  logic                  ack1;
  logic                  wr_en;

  arb_pick2 u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_grant  (last_grant),
    .locked      (locked),
    .owner       (owner),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign owner_req  = (owner == ARB_OWN_P1) ? bus.req1  : bus.req0;
  assign owner_lock = (owner == ARB_OWN_P1) ? bus.lock1 : bus.lock0;

  always_ff @(posedge clk) begin
    if (arst) begin
      state <= ARB_ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      ARB_ST_IDLE: begin
        if (grant_valid) begin
          next_state = ARB_ST_ISSUE;
        end
      end
      ARB_ST_ISSUE: begin
        wr_en      = we_lat;
        next_state = ARB_ST_COMPLETE;
      end
      ARB_ST_COMPLETE: begin
        ack0       = (owner == ARB_OWN_P0);
        ack1       = (owner == ARB_OWN_P1);
        next_state = ARB_ST_IDLE;
      end
      default: begin
        next_state = ARB_ST_IDLE;
      end
    endcase
  end

  // Owner is only meaningful while busy or locked; "none" is locked=0 in IDLE.
  always_ff @(posedge clk) begin
    if (arst) begin
      owner      <= ARB_OWN_P0;
      last_grant <= ARB_OWN_P1;
      locked     <= 1'b0;
      burst_cnt  <= '0;
      we_lat     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      unique case (state)
        ARB_ST_IDLE: begin
          if (locked && !owner_req) begin
            locked    <= 1'b0;
            burst_cnt <= '0;
          end
          if (grant_valid) begin
            owner   <= grant_idx;
            we_lat  <= (grant_idx == ARB_OWN_P1) ? bus.we1    : bus.we0;
            addr_q  <= (grant_idx == ARB_OWN_P1) ? bus.addr1  : bus.addr0;
            wdata_q <= (grant_idx == ARB_OWN_P1) ? bus.wdata1 : bus.wdata0;
          end
        end
        ARB_ST_COMPLETE: begin
          last_grant <= owner;
          if (!we_lat) begin
            if (owner == ARB_OWN_P1) begin
              rdata1_q <= bus.ram_data_rd;
            end else begin
              rdata0_q <= bus.ram_data_rd;
            end
          end
          if (owner_lock && (burst_cnt < BURST_LAST)) begin
            locked    <= 1'b1;
            burst_cnt <= burst_cnt + CNT_W'(1);
          end else begin
            locked    <= 1'b0;
            burst_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read data is forwarded in the ack cycle, then held by the per-port register.
  assign bus.rdata0      = (ack0 && !we_lat) ? bus.ram_data_rd : rdata0_q;
  assign bus.rdata1      = (ack1 && !we_lat) ? bus.ram_data_rd : rdata1_q;
  assign bus.ack0        = ack0;
  assign bus.ack1        = ack1;
  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_data_wr = wdata_q;

endmodule

`default_nettype wire
